instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the CPU core: owns the program counter, drives the read address of the 32-entry × 16-bit combinational program memory, and registers each returned word into an instruction register. The register is handed to the decoder over a valid/ready handshake. The stage also accepts branch redirects and halt requests from downstream and keeps a saturating count of issued instructions.

## Interface

Parameters:
- ADDR_W, 5, program-memory address width (32 words)
- DATA_W, 16, instruction width
- RESET_PC, 0, PC value loaded on reset and on start
- WRAP_EN, 0, 1 = PC wraps 31→0; 0 = stage halts after issuing the last address

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; leaves IDLE or HALT and begins fetching at RESET_PC
- pm_addr  out  ADDR_W  program-memory read address; always equal to the PC register
- pm_data  in  DATA_W  program-memory read data, valid in the same cycle as pm_addr
- ir  out  DATA_W  instruction register
- ir_pc  out  ADDR_W  address that ir was fetched from
- ir_valid  out  1  ir holds an un-consumed instruction
- ir_ready  in  1  decoder accepts ir this cycle
- redirect_valid  in  1  branch taken; flush and refetch
- redirect_addr  in  ADDR_W  branch target
- halt_req  in  1  stop fetching
- halted  out  1  FSM is in HALT
- fetch_count  out  16  instructions issued since start, saturating at 16'hFFFF

## Operation

- FSM states: IDLE, RUN, HALT.
- Reset:
  - State goes to IDLE.
  - pc, ir_pc = RESET_PC.
  - ir = 0, ir_valid = 0, fetch_count = 0, halted = 0.
- IDLE:
  - Holds everything.
  - start → RUN; pc = RESET_PC, fetch_count = 0.
- RUN, load condition = !ir_valid || ir_ready:
  - When the load condition is true: ir ← pm_data, ir_pc ← pc, ir_valid ← 1, pc ← pc+1, fetch_count increments (saturating).
  - When the load condition is false (stall): pc, ir, ir_pc and ir_valid all hold.
- Last-address boundary, pc = 2^ADDR_W−1 and a load occurs:
  - WRAP_EN=1: pc ← 0.
  - WRAP_EN=0: the word is still issued, pc holds, and the state goes to HALT on the same edge.
  - ir_valid stays 1 until that final word is consumed.
- Redirect (RUN only), highest priority:
  - ir_valid ← 0 (flush; a simultaneous ir_ready still completes that handshake for the decoder).
  - pc ← redirect_addr.
  - No load that cycle and no count increment.
  - The first target word appears in ir on the following edge.
- halt_req (RUN only), priority below redirect and above load:
  - State goes to HALT, ir_valid ← 0, pc holds.
- HALT:
  - halted = 1, pm_addr holds.
  - start → RUN with pc = RESET_PC and fetch_count = 0.
  - redirect and halt_req are ignored.
- start is ignored in RUN.
- Reset mid-operation asynchronously returns the stage to IDLE with all reset values; a partially handshaken instruction is lost.

## Timing

- pm_addr is a direct register output with no combinational path from any input.
- Fetch latency is one cycle: a pc value presented in cycle N lands in ir at the end of cycle N.
- Throughput is one instruction per cycle while ir_ready is held high.
- start: the edge after start sees ir_pc = RESET_PC... ir is loaded one edge after entering RUN.
- Redirect costs one bubble cycle.
- A handshake completes on any edge where ir_valid && ir_ready.
- ir_valid never drops without a handshake, redirect, halt or reset.

## Structure

- Shared package: state encoding localparams (IDLE=2'd0, RUN=2'd1, HALT=2'd2), ADDR_W/DATA_W defaults, and the opcode field position [15:11] for downstream use.
- One sub-module: pc_counter. It holds the PC register with load (redirect/start), increment, wrap/last-address flag and hold controls.
- The FSM, instruction register and fetch counter live in instruction_fetch.

## Test plan

- Straight-line run: reset, start, ir_ready=1 for 25 cycles.
  - ir sequence matches program memory words 0..24 with ir_pc 0..24.
  - fetch_count = 25.
- Stall: hold ir_ready=0 for 3 cycles while ir_pc = 4.
  - ir, ir_pc and pm_addr are unchanged.
  - On release, ir_pc 5 follows on the next edge.
- Redirect: redirect_valid with redirect_addr=24 while ir_pc = 22.
  - One cycle with ir_valid=0.
  - Then ir_pc = 24 and ir = word 24 (MOVI R7,#2 encoding).
  - fetch_count does not count the flushed cycle.
- End of memory, WRAP_EN=0: run to address 31.
  - Word 31 (0x0000) is issued, halted=1, and ir_valid drops after the handshake.
  - With WRAP_EN=1, word 0 follows word 31.
- Halt, then restart: assert halt_req at ir_pc=10.
  - halted=1 and ir_valid=0.
  - start gives ir_pc = 0 and fetch_count restarts from 0.
- Async reset mid-stall: assert rst_n=0 between edges.
  - ir_valid=0, pm_addr=0, and the state is IDLE immediately, before the next clock edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, default widths,
// opcode field position and the saturating counter helper.
package instruction_fetch_pkg;

  localparam int IF_ADDR_W = 5;
  localparam int IF_DATA_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_HALT = ST_HALT
  } state_t;

  // Opcode field of an instruction word, used by the decoder.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_counter.sv
// Program counter register with load, increment and last-address handling.
// Without wrap the PC parks on the last address instead of rolling over.
module instruction_fetch_pc_counter
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W   = IF_ADDR_W,
  parameter int RESET_PC = 0,
  parameter bit WRAP_EN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LP_RESET = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LP_LAST  = '1;

  logic [ADDR_W-1:0] r_pc;
  logic              w_hold_last;

  assign o_last      = (r_pc == LP_LAST);
  assign w_hold_last = o_last && !WRAP_EN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= LP_RESET;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc && !w_hold_last) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: FSM, instruction register with valid/ready hand-off to the
// decoder, and a saturating issued-instruction counter.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W   = IF_ADDR_W,
  parameter int DATA_W   = IF_DATA_W,
  parameter int RESET_PC = 0,
  parameter bit WRAP_EN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] pm_addr,
  input  logic [DATA_W-1:0] pm_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);

  state_t            r_state;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_ir_valid;
  logic              r_halted;
  logic [15:0]       r_fetch_count;

  logic              w_run;
  logic              w_start;
  logic              w_redirect;
  logic              w_load;
  logic              w_pc_load;
  logic [ADDR_W-1:0] w_pc_load_addr;
  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_last;

  assign w_run          = (r_state == S_RUN);
  assign w_start        = start && (r_state == S_IDLE || r_state == S_HALT);
  assign w_redirect     = w_run && redirect_valid;
  // Redirect beats halt, halt beats a load.
  assign w_load         = w_run && !redirect_valid && !halt_req && (!r_ir_valid || ir_ready);
  assign w_pc_load      = w_start || w_redirect;
  assign w_pc_load_addr = w_redirect ? redirect_addr : LP_RESET_PC;

  instruction_fetch_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .WRAP_EN  (WRAP_EN)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_pc_load),
    .i_load_addr (w_pc_load_addr),
    .i_inc       (w_load),
    .o_pc        (w_pc),
    .o_last      (w_pc_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ir          <= '0;
      r_ir_pc       <= LP_RESET_PC;
      r_ir_valid    <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_RUN;
            r_fetch_count <= '0;
          end
        end
        S_RUN: begin
          if (redirect_valid) begin
            r_ir_valid <= 1'b0;
          end else if (halt_req) begin
            r_state    <= S_HALT;
            r_halted   <= 1'b1;
            r_ir_valid <= 1'b0;
          end else if (w_load) begin
            r_ir          <= pm_data;
            r_ir_pc       <= w_pc;
            r_ir_valid    <= 1'b1;
            r_fetch_count <= sat_inc16(r_fetch_count);
            // The final word is still issued; the stage parks behind it.
            if (w_pc_last && !WRAP_EN) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (r_ir_valid && ir_ready) begin
            r_ir_valid <= 1'b0;
          end
          if (start) begin
            r_state       <= S_RUN;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pm_addr     = w_pc;
  assign ir          = r_ir;
  assign ir_pc       = r_ir_pc;
  assign ir_valid    = r_ir_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: one non-wrapping and one wrapping instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_instruction_fetch;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NW = 32;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ir_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          halt_req;

  logic [DW-1:0] mem [NW];

  logic [AW-1:0] pm_addr0, pm_addr1, ir_pc0, ir_pc1;
  logic [DW-1:0] pm_data0, pm_data1, ir0, ir1;
  logic          ir_valid0, ir_valid1, halted0, halted1;
  logic [15:0]   fetch_count0, fetch_count1;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  assign pm_data0 = mem[pm_addr0];
  assign pm_data1 = mem[pm_addr1];

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .WRAP_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pm_addr(pm_addr0), .pm_data(pm_data0),
    .ir(ir0), .ir_pc(ir_pc0), .ir_valid(ir_valid0), .ir_ready(ir_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt_req(halt_req),
    .halted(halted0), .fetch_count(fetch_count0)
  );

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .WRAP_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pm_addr(pm_addr1), .pm_data(pm_data1),
    .ir(ir1), .ir_pc(ir_pc1), .ir_valid(ir_valid1), .ir_ready(ir_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt_req(halt_req),
    .halted(halted1), .fetch_count(fetch_count1)
  );

  // Behavioural model, index 0 = no wrap, index 1 = wrap.
  int          m_st   [2];
  int          m_pc   [2];
  logic [15:0] m_ir   [2];
  int          m_irpc [2];
  bit          m_iv   [2];
  int          m_cnt  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] <= M_IDLE; m_pc[k] <= 0; m_ir[k] <= '0;
        m_irpc[k] <= 0; m_iv[k] <= 1'b0; m_cnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_st[k] == M_IDLE) begin
          if (start) begin
            m_st[k] <= M_RUN; m_pc[k] <= 0; m_cnt[k] <= 0;
          end
        end else if (m_st[k] == M_RUN) begin
          if (redirect_valid) begin
            m_iv[k] <= 1'b0;
            m_pc[k] <= int'(redirect_addr);
          end else if (halt_req) begin
            m_st[k] <= M_HALT;
            m_iv[k] <= 1'b0;
          end else if (!m_iv[k] || ir_ready) begin
            m_ir[k]   <= mem[m_pc[k]];
            m_irpc[k] <= m_pc[k];
            m_iv[k]   <= 1'b1;
            m_cnt[k]  <= (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
            if (m_pc[k] == NW - 1 && k == 0) m_st[k] <= M_HALT;
            else m_pc[k] <= (m_pc[k] + 1) % NW;
          end
        end else begin
          if (m_iv[k] && ir_ready) m_iv[k] <= 1'b0;
          if (start) begin
            m_st[k] <= M_RUN; m_pc[k] <= 0; m_cnt[k] <= 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  logic [AW-1:0] a_pm [2], a_irpc [2];
  logic [DW-1:0] a_ir [2];
  logic          a_iv [2], a_h [2];
  logic [15:0]   a_cnt [2];
  assign a_pm[0] = pm_addr0;   assign a_pm[1] = pm_addr1;
  assign a_irpc[0] = ir_pc0;   assign a_irpc[1] = ir_pc1;
  assign a_ir[0] = ir0;        assign a_ir[1] = ir1;
  assign a_iv[0] = ir_valid0;  assign a_iv[1] = ir_valid1;
  assign a_h[0] = halted0;     assign a_h[1] = halted1;
  assign a_cnt[0] = fetch_count0; assign a_cnt[1] = fetch_count1;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("pm_addr", k, int'(a_pm[k]), m_pc[k]);
        chk("ir_valid", k, int'(a_iv[k]), int'(m_iv[k]));
        chk("halted", k, int'(a_h[k]), (m_st[k] == M_HALT) ? 1 : 0);
        chk("fetch_count", k, int'(a_cnt[k]), m_cnt[k]);
        if (m_iv[k]) begin
          chk("ir", k, int'(a_ir[k]), int'(m_ir[k]));
          chk("ir_pc", k, int'(a_irpc[k]), m_irpc[k]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0;
    halt_req = 1'b0; redirect_addr = '0;
    for (int i = 0; i < NW; i++) mem[i] = 16'($urandom) | 16'h0100;
    mem[24] = 16'h3F02;  // MOVI R7,#2
    mem[31] = 16'h0000;
    repeat (2) tick();
    cmp_en = 1'b1;
    chk("rst_ir", 0, int'(ir0), 0);
    chk("rst_ir_valid", 0, int'(ir_valid0), 0);
    chk("rst_pm_addr", 0, int'(pm_addr0), 0);
    chk("rst_ir_pc", 0, int'(ir_pc0), 0);
    chk("rst_count", 0, int'(fetch_count0), 0);
    chk("rst_halted", 0, int'(halted0), 0);
    rst_n = 1'b1;
    tick();

    // Straight-line run
    begin_run();
    chk("start_no_load", 0, int'(ir_valid0), 0);
    ir_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("straight_ir_pc", 0, int'(ir_pc0), i);
    end
    chk("straight_count", 0, int'(fetch_count0), 25);
    chk("straight_word24", 0, int'(ir0), 16'h3F02);
    chk("model_count", 0, m_cnt[0], 25);

    // Stall at ir_pc 4
    do_reset();
    begin_run();
    ir_ready = 1'b1;
    repeat (5) tick();
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ir_pc", 0, int'(ir_pc0), 4);
      chk("stall_pm_addr", 0, int'(pm_addr0), 5);
      chk("stall_ir", 0, int'(ir0), int'(mem[4]));
    end
    ir_ready = 1'b1;
    tick();
    chk("stall_release", 0, int'(ir_pc0), 5);

    // Redirect at ir_pc 22 to 24
    do_reset();
    begin_run();
    ir_ready = 1'b1;
    repeat (23) tick();
    chk("pre_redirect", 0, int'(ir_pc0), 22);
    redirect_valid = 1'b1; redirect_addr = 5'd24;
    tick();
    redirect_valid = 1'b0;
    chk("redir_bubble", 0, int'(ir_valid0), 0);
    chk("redir_count_hold", 0, int'(fetch_count0), 23);
    tick();
    chk("redir_ir_pc", 0, int'(ir_pc0), 24);
    chk("redir_ir", 0, int'(ir0), 16'h3F02);
    chk("redir_count", 0, int'(fetch_count0), 24);
    chk("model_redir", 0, m_irpc[0], 24);

    // End of memory
    do_reset();
    begin_run();
    ir_ready = 1'b1;
    repeat (32) tick();
    chk("end_ir_pc", 0, int'(ir_pc0), 31);
    chk("end_ir", 0, int'(ir0), 0);
    chk("end_halted", 0, int'(halted0), 1);
    chk("end_valid", 0, int'(ir_valid0), 1);
    chk("wrap_not_halted", 1, int'(halted1), 0);
    ir_ready = 1'b0;
    tick();
    chk("end_hold_valid", 0, int'(ir_valid0), 1);
    chk("end_pm_addr", 0, int'(pm_addr0), 31);
    ir_ready = 1'b1;
    tick();
    chk("end_consumed", 0, int'(ir_valid0), 0);
    chk("wrap_ir_pc", 1, int'(ir_pc1), 0);
    chk("wrap_ir", 1, int'(ir1), int'(mem[0]));

    // Halt then restart
    do_reset();
    begin_run();
    ir_ready = 1'b1;
    repeat (11) tick();
    chk("pre_halt", 0, int'(ir_pc0), 10);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_halted", 0, int'(halted0), 1);
    chk("halt_valid", 0, int'(ir_valid0), 0);
    tick();
    begin_run();
    chk("restart_count", 0, int'(fetch_count0), 0);
    chk("restart_halted", 0, int'(halted0), 0);
    tick();
    chk("restart_ir_pc", 0, int'(ir_pc0), 0);
    chk("restart_count1", 0, int'(fetch_count0), 1);

    // Async reset during a stall
    ir_ready = 1'b1;
    repeat (3) tick();
    ir_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 0, int'(ir_valid0), 0);
    chk("async_pm_addr", 0, int'(pm_addr0), 0);
    chk("async_halted", 0, int'(halted0), 0);
    chk("async_count", 0, int'(fetch_count0), 0);
    tick();
    rst_n = 1'b1;
    ir_ready = 1'b1;
    repeat (2) tick();
    chk("async_idle", 0, int'(ir_valid0), 0);

    // Randomized traffic
    do_reset();
    begin_run();
    for (int c = 0; c < 3000; c++) begin
      ir_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = AW'($urandom);
      halt_req       = ($urandom_range(0, 39) == 0);
      start          = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
